// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encoding for the ALU arbiter.
package alu_pkg;

    localparam int unsigned OPW = 6;
    localparam logic [OPW-1:0] OP_ADD = 6'b100000;
    localparam logic [OPW-1:0] OP_SUB = 6'b100010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; ptr names the requester preferred on contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = '0;
        if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
        else              grant = req;
    end

    // Granting 0 hands preference to 1 and vice versa.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ptr <= 1'b0;
        else if (advance) ptr <= grant[0];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Optional: ALU_OPCODE_CHECK_EN rejects non-ADD/SUB opcodes without using the ALU.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic [5:0]       req0_opcode,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic [5:0]       req1_opcode,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [5:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    state_t          state, state_nxt;
    logic [1:0]      grant;
    logic            granted, gid, id_q, op_ok, err_q;
    logic [WIDTH-1:0] sel_in1, sel_in2;
    logic [5:0]      sel_op;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ((state == IDLE) ? req_valid : 2'b00),
        .advance (granted),
        .grant   (grant)
    );

    assign granted   = |grant;
    assign gid       = grant[1];
    assign req_ready = grant;
    assign resp_err  = err_q;
    assign sel_in1   = gid ? req1_in1    : req0_in1;
    assign sel_in2   = gid ? req1_in2    : req0_in2;
    assign sel_op    = gid ? req1_opcode : req0_opcode;

`ifdef ALU_OPCODE_CHECK_EN
    assign op_ok = is_alu_op(sel_op);
`else
    assign op_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (granted) state_nxt = op_ok ? EXEC : RESP;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q       <= 1'b0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_opcode <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_out   <= '0;
            resp_zero  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (granted) begin
                    id_q <= gid;
                    if (op_ok) begin
                        alu_in1    <= sel_in1;
                        alu_in2    <= sel_in2;
                        alu_opcode <= sel_op;
                    end else begin
                        // Rejected opcode: answer directly, ALU registers untouched.
                        resp_valid <= 1'b1;
                        resp_id    <= gid;
                        resp_out   <= '0;
                        resp_zero  <= 1'b1;
                        err_q      <= 1'b1;
                    end
                end
                EXEC: begin
                    resp_valid <= 1'b1;
                    resp_id    <= id_q;
                    resp_out   <= alu_out;
                    resp_zero  <= alu_zero;
                    err_q      <= 1'b0;
                end
                RESP: if (resp_ready) resp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [5:0]  req0_opcode, req1_opcode;
    logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [31:0] resp_out, alu_in1, alu_in2, alu_out;
    logic [5:0]  alu_opcode;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign alu_out  = (alu_opcode == OP_ADD) ? alu_in1 + alu_in2 :
                      (alu_opcode == OP_SUB) ? alu_in1 - alu_in2 : 32'd0;
    assign alu_zero = (alu_out == 32'd0);

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_opcode(req0_opcode),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_opcode(req1_opcode),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Presents a request at a falling edge; returns at the falling edge after the grant.
    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] op, output bit got);
        got = 1'b0;
        if (id == 0) begin req0_in1 = a; req0_in2 = b; req0_opcode = op; end
        else         begin req1_in1 = a; req1_in2 = b; req1_opcode = op; end
        req_valid[id] = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (req_ready[id]) got = 1'b1;
            @(negedge clk);
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
        req0_in1 = '0; req0_in2 = '0; req0_opcode = '0;
        req1_in1 = '0; req1_in2 = '0; req1_opcode = '0;
        #3;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        checks++; if ({resp_valid, resp_id, resp_zero, resp_err} !== 4'b0000) begin errors++; $display("FAIL reset_resp_flags got %b exp 0000", {resp_valid, resp_id, resp_zero, resp_err}); end
        checks++; if (resp_out !== 32'd0) begin errors++; $display("FAIL reset_resp_out got %h exp 0", resp_out); end
        checks++; if ({alu_in1, alu_in2, alu_opcode} !== 70'd0) begin errors++; $display("FAIL reset_alu_regs got %h %h %b exp 0", alu_in1, alu_in2, alu_opcode); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit got; int n;
        req0_in1 = 32'd5; req0_in2 = 32'd3; req0_opcode = OP_ADD; req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_exec got %b exp 00", req_ready); end
        checks++; if (alu_in1 !== 32'd5 || alu_in2 !== 32'd3 || alu_opcode !== OP_ADD) begin errors++; $display("FAIL single_alu_regs got %0d %0d %b exp 5 3 100000", alu_in1, alu_in2, alu_opcode); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", resp_valid); end
        wait_resp(n);
        checks++; if (n !== 1 || resp_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %0d valid %b exp 1 1", n, resp_valid); end
        checks++; if (resp_out !== 32'd8 || resp_zero !== 1'b0 || resp_id !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL single_resp got %0d z%b id%b e%b exp 8 z0 id0 e0", resp_out, resp_zero, resp_id, resp_err); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || resp_out !== 32'd8) begin errors++; $display("FAIL single_drop got valid %b out %0d exp 0 8", resp_valid, resp_out); end
        got = 1'b0;
    endtask

    task automatic test_zero_flag;
        bit got; int n;
        send(1, 32'd7, 32'd7, OP_SUB, got);
        wait_resp(n);
        checks++; if (!got || resp_valid !== 1'b1) begin errors++; $display("FAIL zero_handshake got grant %b valid %b exp 1 1", got, resp_valid); end
        checks++; if (resp_out !== 32'd0 || resp_zero !== 1'b1 || resp_id !== 1'b1) begin errors++; $display("FAIL zero_sub_equal got %h z%b id%b exp 0 z1 id1", resp_out, resp_zero, resp_id); end
        @(negedge clk);
        send(1, 32'd0, 32'd1, OP_SUB, got);
        wait_resp(n);
        checks++; if (resp_out !== 32'hFFFFFFFF || resp_zero !== 1'b0 || resp_id !== 1'b1) begin errors++; $display("FAIL zero_sub_wrap got %h z%b id%b exp ffffffff z0 id1", resp_out, resp_zero, resp_id); end
        @(negedge clk);
    endtask

    task automatic test_contention;
        logic [1:0]  grants[$];
        logic        ids[$];
        logic [31:0] outs[$];
        bit multi = 1'b0;
        req0_in1 = 32'd10; req0_in2 = 32'd20; req0_opcode = OP_ADD;
        req1_in1 = 32'd50; req1_in2 = 32'd8;  req1_opcode = OP_SUB;
        req_valid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req_ready == 2'b11) multi = 1'b1;
            if (req_ready != 2'b00) grants.push_back(req_ready);
            if (resp_valid) begin ids.push_back(resp_id); outs.push_back(resp_out); end
            @(negedge clk);
        end
        req_valid = 2'b00;
        checks++; if (multi || grants.size() != 4) begin errors++; $display("FAIL contention_grant_count got %0d multi %b exp 4 0", grants.size(), multi); end
        checks++; if (grants.size() == 4 && (grants[0] !== 2'b01 || grants[1] !== 2'b10 || grants[2] !== 2'b01 || grants[3] !== 2'b10)) begin errors++; $display("FAIL contention_grant_order got %b %b %b %b exp 01 10 01 10", grants[0], grants[1], grants[2], grants[3]); end
        checks++; if (ids.size() != 4) begin errors++; $display("FAIL contention_resp_count got %0d exp 4", ids.size()); end
        else begin
            checks++; if (ids[0] !== 1'b0 || ids[1] !== 1'b1 || ids[2] !== 1'b0 || ids[3] !== 1'b1) begin errors++; $display("FAIL contention_ids got %b%b%b%b exp 0101", ids[0], ids[1], ids[2], ids[3]); end
            checks++; if (outs[0] !== 32'd30 || outs[1] !== 32'd42 || outs[2] !== 32'd30 || outs[3] !== 32'd42) begin errors++; $display("FAIL contention_outs got %0d %0d %0d %0d exp 30 42 30 42", outs[0], outs[1], outs[2], outs[3]); end
        end
    endtask

    task automatic test_backpressure;
        bit got; int n; bit moved = 1'b0;
        resp_ready = 1'b0;
        send(0, 32'd100, 32'd1, OP_SUB, got);
        wait_resp(n);
        checks++; if (resp_valid !== 1'b1 || resp_out !== 32'd99) begin errors++; $display("FAIL bp_first got valid %b out %0d exp 1 99", resp_valid, resp_out); end
        req1_in1 = 32'd1; req1_in2 = 32'd2; req1_opcode = OP_ADD; req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (resp_valid !== 1'b1 || resp_out !== 32'd99 || resp_id !== 1'b0 || resp_zero !== 1'b0 || req_ready !== 2'b00) moved = 1'b1;
            @(negedge clk);
        end
        checks++; if (moved) begin errors++; $display("FAIL bp_hold got unstable resp or ready=%b exp stable 99 ready 00", req_ready); end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 2'b10) begin errors++; $display("FAIL bp_release got valid %b ready %b exp 0 10", resp_valid, req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(n);
        checks++; if (resp_valid !== 1'b1 || resp_out !== 32'd3 || resp_id !== 1'b1) begin errors++; $display("FAIL bp_next got valid %b out %0d id %b exp 1 3 1", resp_valid, resp_out, resp_id); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        bit got; int n; bit stale = 1'b0;
        send(0, 32'd2, 32'd2, OP_ADD, got);
        rst = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || alu_in1 !== 32'd0 || alu_opcode !== 6'd0 || req_ready !== 2'b00) begin errors++; $display("FAIL midop_async got valid %b in1 %0d op %b ready %b exp 0 0 0 00", resp_valid, alu_in1, alu_opcode, req_ready); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) stale = 1'b1;
        end
        checks++; if (stale) begin errors++; $display("FAIL midop_stale got resp_valid 1 exp 0"); end
        req0_in1 = 32'd11; req0_in2 = 32'd22; req0_opcode = OP_ADD;
        req1_in1 = 32'd3;  req1_in2 = 32'd4;  req1_opcode = OP_ADD;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midop_priority got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(n);
        checks++; if (resp_out !== 32'd33 || resp_id !== 1'b0) begin errors++; $display("FAIL midop_result got %0d id %b exp 33 0", resp_out, resp_id); end
        @(negedge clk);
    endtask

    task automatic test_opcode;
        bit got; int n;
        send(0, 32'd9, 32'd4, 6'b000001, got);
`ifdef ALU_OPCODE_CHECK_EN
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_out !== 32'd0 || resp_zero !== 1'b1) begin errors++; $display("FAIL opcode_reject got v%b e%b out %0d z%b exp v1 e1 0 z1", resp_valid, resp_err, resp_out, resp_zero); end
        checks++; if (alu_in1 !== 32'd11 || alu_opcode !== OP_ADD) begin errors++; $display("FAIL opcode_alu_kept got %0d %b exp 11 100000", alu_in1, alu_opcode); end
`else
        checks++; if (resp_valid !== 1'b0 || alu_opcode !== 6'b000001) begin errors++; $display("FAIL opcode_exec got valid %b op %b exp 0 000001", resp_valid, alu_opcode); end
        wait_resp(n);
        checks++; if (n !== 1 || resp_err !== 1'b0 || resp_out !== 32'd0 || resp_zero !== 1'b1) begin errors++; $display("FAIL opcode_default got n%0d e%b out %0d z%b exp 1 e0 0 z1", n, resp_err, resp_out, resp_zero); end
`endif
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_single;
        test_zero_flag;
        test_contention;
        test_backpressure;
        test_reset_midop;
        test_opcode;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance between two requesters (e.g. fetch/PC-increment unit and execute stage) using round-robin arbitration. Each request carries in1, in2 and opcode over a valid/ready handshake. The block drives the ALU operands from registers, captures out/zero one cycle later, and returns the result over a valid/ready response channel tagged with the requester id. It sits between the pipeline control and the alu in the cpu top level.

Parameters:
WIDTH, 32, operand/result width; must match the alu WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
req_valid  input  2  per-requester request valid; bit i = requester i
req_ready  output  2  per-requester accept; at most one bit high per cycle
req0_in1, req0_in2  input  WIDTH each  requester 0 operands
req0_opcode  input  6  requester 0 opcode
req1_in1, req1_in2  input  WIDTH each  requester 1 operands
req1_opcode  input  6  requester 1 opcode
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts response
resp_id  output  1  requester that owns the response
resp_out  output  WIDTH  captured alu result
resp_zero  output  1  captured alu zero flag
resp_err  output  1  unsupported opcode (see Optional Feature)
alu_in1, alu_in2  output  WIDTH each  registered operands to alu
alu_opcode  output  6  registered opcode to alu
alu_out  input  WIDTH  alu result (combinational from alu_* outputs)
alu_zero  input  1  alu zero flag

Behaviour:
- Reset (rst=0, async): state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_out=0, resp_zero=0, resp_err=0, alu_in1/alu_in2/alu_opcode=0, rr pointer=0 (requester 0 has priority first).
- FSM states: IDLE, EXEC, RESP. One operation in flight at a time; no pipelining.
- IDLE: if any req_valid, grant one requester combinationally: req_ready[g]=1 for that cycle only. On the edge, latch its in1/in2/opcode into alu_* registers, store id g, go to EXEC. If none valid, stay IDLE, req_ready=0.
- Round-robin: if both valid, grant the requester != last granted. rr pointer updates only on an actual grant. Single valid requester is granted regardless of pointer.
- EXEC: one cycle; alu settles. On the edge, capture alu_out→resp_out, alu_zero→resp_zero, id→resp_id, set resp_valid=1, go to RESP.
- RESP: hold resp_* stable while resp_valid=1 and resp_ready=0. When resp_ready=1: resp_valid drops next cycle, go to IDLE. resp_out/resp_zero/resp_id keep last value after drop.
- Latency: grant edge → resp_valid high 2 cycles later. Throughput: one op per 3 cycles if resp_ready held high.
- req_ready is 0 in EXEC and RESP; requesters must hold valid and operands stable until ready.
- alu_* registers hold last operands outside EXEC; no further alu activity until next grant.
- Arithmetic: done entirely by alu (ADD 6'b100000, SUB 6'b100010, others → out=0, zero=1); wrap-around modulo 2^WIDTH; the arbiter does not modify results.
- Reset mid-operation: in-flight op is dropped, no response produced, state returns to IDLE.
- req_valid deasserted by a requester while not granted: no effect, no state.

Optional Feature:
ALU_OPCODE_CHECK_EN.
- Defined: in IDLE, a granted request with opcode not ADD/SUB still completes the handshake, skips EXEC (IDLE→RESP directly), sets resp_err=1, resp_out=0, resp_zero=1; alu_* registers unchanged.
- Undefined: resp_err constant 0; all opcodes go through EXEC and the alu default (out=0, zero=1) applies.

Decomposition:
- Shared package alu_pkg: OP_ADD=6'b100000, OP_SUB=6'b100010, opcode width 6, FSM state encoding (IDLE/EXEC/RESP, 2 bits).
- Sub-module rr_arb2: 2-input round-robin arbiter (req[1:0], advance, grant[1:0], pointer register; clk/rst same polarity).

Test Plan:
- Single request: req0 valid, in1=5, in2=3, op ADD, resp_ready=1 → req_ready=2'b01 one cycle; 2 cycles later resp_valid=1, resp_out=8, resp_zero=0, resp_id=0.
- Zero flag: req1 SUB 7,7 → resp_out=0, resp_zero=1, resp_id=1; SUB 0,1 → resp_out=32'hFFFFFFFF, zero=0.
- Contention: both valid continuously, resp_ready=1 → grants alternate 0,1,0,1; 4 responses with ids 0,1,0,1.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → resp_* stable, req_ready=0 throughout; resp_ready=1 → IDLE next cycle, next grant follows.
- Reset mid-op: rst=0 during EXEC → all outputs 0 immediately (async); after release, no stale response, req0 priority restored.
- Opcode 6'b000001 with ALU_OPCODE_CHECK_EN: resp_err=1, resp_out=0, resp_zero=1 one cycle after grant; without macro: resp_err=0, resp_out=0, resp_zero=1 after 2 cycles.
